// File: rtl/image_sink_pkg.sv
// Shared constants for the image_sink frame capture block: DP bus bit
// positions, default frame geometry and the capture FSM encoding.
package image_sink_pkg;

    localparam int DP_W     = 27;
    localparam int DP_VSYNC = 26;
    localparam int DP_HSYNC = 25;
    localparam int DP_DE    = 24;
    localparam int PIX_MSB  = 23;
    localparam int PIX_LSB  = 0;
    localparam int PIX_W    = PIX_MSB - PIX_LSB + 1;

    localparam int DEF_BPP    = 24;
    localparam int DEF_WIDTH  = 1280;
    localparam int DEF_HEIGHT = 720;
    localparam int DEF_ADDR_W = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/image_sink_if.sv
// Pixel input bus and frame-buffer write port of image_sink.
// The source side drives DPi and observes the write strobe.
interface image_sink_if
    import image_sink_pkg::*;
#(
    parameter int BPP    = DEF_BPP,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [DP_W-1:0]   DPi;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BPP-1:0]    wr_data;

    modport master (output DPi, input wr_en, wr_addr, wr_data);
    modport slave  (input DPi, output wr_en, wr_addr, wr_data);

endinterface

// File: rtl/image_sink_timing.sv
// Frame pixel counter and line pixel counter with the per-line width check.
// pix_cnt_o is the raster address of a pixel accepted in the current cycle.
module image_sink_timing
    import image_sink_pkg::*;
#(
    parameter int EXP_WIDTH = DEF_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    input  logic              line_start_i,
    input  logic              pix_en_i,
    output logic [ADDR_W-1:0] pix_cnt_o,
    output logic              line_end_o,
    output logic              width_err_o
);

    // One spare bit so a line running long without hsync cannot alias EXP_WIDTH.
    localparam int LINE_W = ADDR_W + 1;

    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;

    always_comb begin
        pix_cnt_d  = frame_start_i ? '0 : pix_cnt_q;
        line_cnt_d = line_start_i  ? '0 : line_cnt_q;
        if (pix_en_i) begin
            pix_cnt_d  = pix_cnt_d + ADDR_W'(1);
            line_cnt_d = line_cnt_d + LINE_W'(1);
        end
    end

    assign pix_cnt_o   = frame_start_i ? '0 : pix_cnt_q;
    assign line_end_o  = pix_en_i && (line_cnt_d == LINE_W'(EXP_WIDTH));
    assign width_err_o = line_start_i && (line_cnt_q != '0)
                         && (line_cnt_q != LINE_W'(EXP_WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
        end
    end

endmodule

// File: rtl/image_sink.sv
// Frame capture: writes DP pixels to a frame buffer in raster order, tracks
// completed frames, a per-frame checksum and sticky geometry error flags.
module image_sink
    import image_sink_pkg::*;
#(
    parameter int BPP        = DEF_BPP,
    parameter int EXP_WIDTH  = DEF_WIDTH,
    parameter int EXP_HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    image_sink_if.slave  bus,
    output logic         frame_done,
    output logic [15:0]  frame_cnt,
    output logic [31:0]  checksum,
    output logic         width_err,
    output logic         height_err,
    output logic         overflow
);

    localparam int TOTAL = EXP_WIDTH * EXP_HEIGHT;

    state_e             state_q, state_d;
    logic               vsync, hsync, de;
    logic [PIX_W-1:0]   pix;
    logic               accept, frame_last, herr_set, ovf_set;
    logic [ADDR_W-1:0]  pix_addr;
    logic               width_mis, line_end_unused;
    logic [31:0]        sum_q, sum_d;
    logic               wr_en_q, frame_done_q, width_err_q, height_err_q, overflow_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [BPP-1:0]     wr_data_q;
    logic [15:0]        frame_cnt_q;
    logic [31:0]        checksum_q;

    assign vsync = bus.DPi[DP_VSYNC];
    assign hsync = bus.DPi[DP_HSYNC];
    assign de    = bus.DPi[DP_DE];
    assign pix   = bus.DPi[PIX_MSB:PIX_LSB];

    // vsync restarts capture in any state, so a pixel sharing its cycle is kept.
    assign accept     = de && (vsync || state_q == ACTIVE);
    assign frame_last = accept && (pix_addr == ADDR_W'(TOTAL - 1));

    image_sink_timing #(
        .EXP_WIDTH (EXP_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (vsync),
        .line_start_i  (vsync || (hsync && state_q != IDLE)),
        .pix_en_i      (accept),
        .pix_cnt_o     (pix_addr),
        .line_end_o    (line_end_unused),
        .width_err_o   (width_mis)
    );

    always_comb begin
        state_d  = state_q;
        herr_set = 1'b0;
        ovf_set  = 1'b0;
        sum_d    = (vsync ? '0 : sum_q) + (accept ? 32'(pix) : '0);
        unique case (state_q)
            IDLE:    if (vsync) state_d = ACTIVE;
            ACTIVE:  if (vsync) herr_set = 1'b1;
            DONE: begin
                if (vsync)   state_d = ACTIVE;
                else if (de) ovf_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (frame_last) state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sum_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            checksum_q   <= '0;
            width_err_q  <= 1'b0;
            height_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            wr_en_q      <= accept;
            wr_addr_q    <= pix_addr;
            wr_data_q    <= BPP'(pix);
            frame_done_q <= frame_last;
            if (frame_last) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                checksum_q  <= sum_d;
            end
            width_err_q  <= width_err_q  | width_mis;
            height_err_q <= height_err_q | herr_set;
            overflow_q   <= overflow_q   | ovf_set;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign checksum    = checksum_q;
    assign width_err   = width_err_q;
    assign height_err  = height_err_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_image_sink.sv
// Bench for image_sink: directed and random DP streams checked against a
// queue-based frame model; a second, larger instance checks a full frame.
module tb_image_sink;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int BW = 64;
    localparam int BH = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic        fd, werr, herr, ovf;
    logic [15:0] fcnt;
    logic [31:0] csum;
    logic        fd_b, werr_b, herr_b, ovf_b;
    logic [15:0] fcnt_b;
    logic [31:0] csum_b;

    image_sink_if #(.BPP(24), .ADDR_W(4))  bus_s ();
    image_sink_if #(.BPP(24), .ADDR_W(12)) bus_b ();

    image_sink #(.BPP(24), .EXP_WIDTH(W), .EXP_HEIGHT(H), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .frame_done(fd), .frame_cnt(fcnt),
        .checksum(csum), .width_err(werr), .height_err(herr), .overflow(ovf)
    );

    image_sink #(.BPP(24), .EXP_WIDTH(BW), .EXP_HEIGHT(BH), .ADDR_W(12)) dut_big (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .frame_done(fd_b), .frame_cnt(fcnt_b),
        .checksum(csum_b), .width_err(werr_b), .height_err(herr_b), .overflow(ovf_b)
    );

    // Frame model: capture flags, pixels of the current frame, current line length.
    bit          m_cap, m_cmp;
    int          m_line;
    logic [23:0] m_px[$];
    logic        e_we, e_fd, e_werr, e_herr, e_ovf;
    logic [3:0]  e_addr;
    logic [23:0] e_data;
    logic [15:0] e_cnt;
    logic [31:0] e_sum;

    task automatic model_reset();
        m_cap = 1'b0; m_cmp = 1'b0; m_line = 0; m_px.delete();
        e_we = 1'b0; e_fd = 1'b0; e_addr = '0; e_data = '0;
        e_cnt = '0; e_sum = '0; e_werr = 1'b0; e_herr = 1'b0; e_ovf = 1'b0;
    endtask

    // Drive one DP cycle, predict the outputs it produces, sample #1 after the edge.
    task automatic step(input logic vs, input logic hs, input logic de, input logic [23:0] px);
        bus_s.DPi = {vs, hs, de, px};
        e_we = 1'b0;
        e_fd = 1'b0;
        if (vs) begin
            if (m_cap && !m_cmp) e_herr = 1'b1;
            if (m_line != 0 && m_line != W) e_werr = 1'b1;
            m_px.delete(); m_line = 0; m_cap = 1'b1; m_cmp = 1'b0;
        end else if (hs && m_cap) begin
            if (m_line != 0 && m_line != W) e_werr = 1'b1;
            m_line = 0;
        end
        if (de) begin
            if (m_cap && !m_cmp) begin
                e_we = 1'b1; e_addr = 4'(m_px.size()); e_data = px;
                m_px.push_back(px); m_line++;
                if (m_px.size() == W * H) begin
                    m_cmp = 1'b1; e_fd = 1'b1; e_cnt++;
                    e_sum = '0;
                    foreach (m_px[i]) e_sum += 32'(m_px[i]);
                end
            end else if (m_cmp) begin
                e_ovf = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        bus_s.DPi = '0; bus_b.DPi = '0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_s.DPi = '0; bus_b.DPi = '0;
        model_reset();
        repeat (2) @(posedge clk); #1;
        vectors++;
        if ({bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data, fd, fcnt, csum, werr, herr, ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h required 0",
                     {bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data, fd, fcnt, csum, werr, herr, ovf});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, i == 0 || i == 4, 1'b1, 24'(i + 1));
            vectors++;
            if (bus_s.wr_en !== 1'b0 || werr !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_ignore cyc %0d got wr_en=%b width_err=%b required 0 0", i, bus_s.wr_en, werr);
            end
        end
    endtask

    task automatic test_full_frame();
        int nfd = 0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int l = 0; l < H; l++) begin
            for (int p = 0; p < W; p++) begin
                step(1'b0, p == 0, 1'b1, 24'(l * W + p + 1));
                if (fd === 1'b1) nfd++;
                vectors++;
                if (bus_s.wr_en !== 1'b1 || bus_s.wr_addr !== 4'(l * W + p) || bus_s.wr_data !== e_data) begin
                    miscompares++;
                    $display("FAIL full_write px %0d got en=%b addr=%0d data=%h required 1 %0d %h",
                             l * W + p, bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data, l * W + p, e_data);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, 24'd0);
        if (fd === 1'b1) nfd++;
        vectors++;
        if (nfd != 1) begin
            miscompares++; $display("FAIL full_frame_done got %0d pulses required 1", nfd);
        end
        vectors++;
        if (csum !== 32'd36 || csum !== e_sum) begin
            miscompares++; $display("FAIL full_checksum got %0d required 36", csum);
        end
        vectors++;
        if (fcnt !== 16'd1) begin
            miscompares++; $display("FAIL full_frame_cnt got %0d required 1", fcnt);
        end
        vectors++;
        if ({werr, herr, ovf} !== 3'b000) begin
            miscompares++; $display("FAIL full_errors got %b required 000", {werr, herr, ovf});
        end
    endtask

    task automatic test_short_line();
        int nfd = 0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int p = 0; p < W; p++) begin
            step(1'b0, p == 0, 1'b1, 24'($urandom));
            if (fd === 1'b1) nfd++;
        end
        for (int p = 0; p < W - 1; p++) begin
            step(1'b0, p == 0, 1'b1, 24'($urandom));
            if (fd === 1'b1) nfd++;
        end
        vectors++;
        if (werr !== 1'b0) begin
            miscompares++; $display("FAIL short_line_early got width_err=%b required 0", werr);
        end
        step(1'b0, 1'b1, 1'b0, 24'd0);
        vectors++;
        if (werr !== 1'b1 || werr !== e_werr) begin
            miscompares++; $display("FAIL short_line_werr got %b required 1", werr);
        end
        vectors++;
        if (nfd != 0) begin
            miscompares++; $display("FAIL short_line_no_done got %0d pulses required 0", nfd);
        end
        step(1'b0, 1'b0, 1'b1, 24'($urandom));
        vectors++;
        if (fd !== 1'b1 || bus_s.wr_addr !== 4'd7 || csum !== e_sum) begin
            miscompares++;
            $display("FAIL short_line_done got fd=%b addr=%0d sum=%h required 1 7 %h", fd, bus_s.wr_addr, csum, e_sum);
        end
    endtask

    task automatic test_short_frame();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 5; i++) step(1'b0, i % W == 0, 1'b1, 24'($urandom));
        step(1'b1, 1'b0, 1'b0, 24'd0);
        vectors++;
        if (herr !== 1'b1 || fd !== 1'b0) begin
            miscompares++; $display("FAIL short_frame_herr got herr=%b fd=%b required 1 0", herr, fd);
        end
        vectors++;
        if (werr !== e_werr) begin
            miscompares++; $display("FAIL short_frame_werr got %b required %b", werr, e_werr);
        end
        step(1'b0, 1'b1, 1'b1, 24'h5A5A5A);
        vectors++;
        if (bus_s.wr_en !== 1'b1 || bus_s.wr_addr !== 4'd0 || fcnt !== 16'd0) begin
            miscompares++;
            $display("FAIL short_frame_restart got en=%b addr=%0d cnt=%0d required 1 0 0", bus_s.wr_en, bus_s.wr_addr, fcnt);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < W * H; i++) step(1'b0, i % W == 0, 1'b1, 24'($urandom));
        vectors++;
        if (ovf !== 1'b0 || fcnt !== 16'd1 || csum !== e_sum) begin
            miscompares++; $display("FAIL ovf_pre got ovf=%b cnt=%0d sum=%h required 0 1 %h", ovf, fcnt, csum, e_sum);
        end
        step(1'b0, 1'b0, 1'b1, 24'($urandom));
        vectors++;
        if (bus_s.wr_en !== 1'b0 || ovf !== 1'b1) begin
            miscompares++; $display("FAIL ovf_extra got en=%b ovf=%b required 0 1", bus_s.wr_en, ovf);
        end
    endtask

    task automatic test_vsync_valid();
        apply_reset();
        step(1'b0, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b1, 24'hABCDEF);
        vectors++;
        if (bus_s.wr_en !== 1'b1 || bus_s.wr_addr !== 4'd0 || bus_s.wr_data !== 24'hABCDEF) begin
            miscompares++;
            $display("FAIL vs_valid_first got en=%b addr=%0d data=%h required 1 0 abcdef", bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data);
        end
        step(1'b0, 1'b0, 1'b1, 24'h123456);
        vectors++;
        if (bus_s.wr_en !== 1'b1 || bus_s.wr_addr !== 4'd1 || bus_s.wr_data !== 24'h123456) begin
            miscompares++;
            $display("FAIL vs_valid_second got en=%b addr=%0d data=%h required 1 1 123456", bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nfd = 0;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) step(1'b0, i == 0, 1'b1, 24'($urandom));
        bus_s.DPi = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data, fd, fcnt, csum, werr, herr, ovf} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs got %h required 0",
                     {bus_s.wr_en, bus_s.wr_addr, bus_s.wr_data, fd, fcnt, csum, werr, herr, ovf});
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i == 0, 1'b1, 24'($urandom));
            vectors++;
            if (bus_s.wr_en !== 1'b0) begin
                miscompares++; $display("FAIL midreset_ignore cyc %0d got wr_en=%b required 0", i, bus_s.wr_en);
            end
        end
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < W * H; i++) begin
            step(1'b0, i % W == 0, 1'b1, 24'($urandom));
            if (fd === 1'b1) nfd++;
        end
        vectors++;
        if (fcnt !== 16'd1 || nfd != 1 || csum !== e_sum || {werr, herr, ovf} !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_frame got cnt=%0d done=%0d sum=%h err=%b required 1 1 %h 000",
                     fcnt, nfd, csum, {werr, herr, ovf}, e_sum);
        end
    endtask

    task automatic test_random_frames();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 75, 24'($urandom));
            vectors++;
            if (bus_s.wr_en !== e_we) begin
                miscompares++; $display("FAIL rand_wr_en cyc %0d got %b required %b", i, bus_s.wr_en, e_we);
            end
            if (e_we) begin
                vectors++;
                if (bus_s.wr_addr !== e_addr || bus_s.wr_data !== e_data) begin
                    miscompares++;
                    $display("FAIL rand_write cyc %0d got %0d/%h required %0d/%h", i, bus_s.wr_addr, bus_s.wr_data, e_addr, e_data);
                end
            end
            vectors++;
            if ({fd, fcnt, csum} !== {e_fd, e_cnt, e_sum}) begin
                miscompares++;
                $display("FAIL rand_frame cyc %0d got fd=%b cnt=%0d sum=%h required %b %0d %h", i, fd, fcnt, csum, e_fd, e_cnt, e_sum);
            end
            vectors++;
            if ({werr, herr, ovf} !== {e_werr, e_herr, e_ovf}) begin
                miscompares++;
                $display("FAIL rand_flags cyc %0d got %b required %b", i, {werr, herr, ovf}, {e_werr, e_herr, e_ovf});
            end
        end
    endtask

    task automatic test_large_frame();
        logic [31:0] sum_exp = '0;
        logic [23:0] px;
        logic [23:0] sent[$];
        int nwr = 0;
        int nfd = 0;
        apply_reset();
        bus_b.DPi = {3'b100, 24'd0};
        @(posedge clk); #1;
        for (int k = 0; k <= BW * BH; k++) begin
            if (k < BW * BH) begin
                px = 24'($urandom);
                sum_exp += 32'(px);
                sent.push_back(px);
                bus_b.DPi = {1'b0, k % BW == 0, 1'b1, px};
            end else begin
                bus_b.DPi = '0;
            end
            @(posedge clk); #1;
            if (fd_b === 1'b1) nfd++;
            if (bus_b.wr_en === 1'b1) begin
                vectors++;
                if (sent.size() == 0 || bus_b.wr_addr !== 12'(nwr) || bus_b.wr_data !== sent[0]) begin
                    miscompares++;
                    $display("FAIL large_write idx %0d got addr=%0d data=%h", nwr, bus_b.wr_addr, bus_b.wr_data);
                end
                if (sent.size() != 0) void'(sent.pop_front());
                nwr++;
            end
        end
        vectors++;
        if (nwr != BW * BH || nfd != 1) begin
            miscompares++; $display("FAIL large_count got %0d writes %0d done required %0d 1", nwr, nfd, BW * BH);
        end
        vectors++;
        if (csum_b !== sum_exp || fcnt_b !== 16'd1) begin
            miscompares++; $display("FAIL large_checksum got %h cnt=%0d required %h 1", csum_b, fcnt_b, sum_exp);
        end
        vectors++;
        if ({werr_b, herr_b, ovf_b} !== 3'b000) begin
            miscompares++; $display("FAIL large_errors got %b required 000", {werr_b, herr_b, ovf_b});
        end
    endtask

    initial begin
        bus_s.DPi = '0;
        bus_b.DPi = '0;
        test_reset();
        test_full_frame();
        test_short_line();
        test_short_frame();
        test_overflow();
        test_vsync_valid();
        test_reset_mid_frame();
        test_random_frames();
        test_large_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
